// File: rtl/adder_arbiter_rr.sv
// Two-requester round-robin front end sharing one 4-bit adder.
// Operands are captured on accept, held CALC_CYCLES cycles on the adder, then the sum is registered.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] s
);
    assign s = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter_rr #(
    parameter int unsigned CALC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [4:0] s,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

    state_t     state_r, state_s;
    logic [3:0] opa_r, opa_s, opb_r, opb_s;
    logic [3:0] cnt_r, cnt_s;
    logic       last_r, last_s;
    logic       owner_r, owner_s;
    logic       win_s;
    logic       gnt0_r, gnt0_s, gnt1_r, gnt1_s;
    logic       done0_r, done0_s, done1_r, done1_s;
    logic       busy_r, busy_s;
    logic [4:0] s_r, s_s;
    logic [4:0] sum_s;

    adder4 u_adder (
        .a (opa_r),
        .b (opb_r),
        .s (sum_s)
    );

    // Next-state and next-output decode; last_r names the requester that must yield on a tie.
    always_comb begin
        state_s = state_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        owner_s = owner_r;
        win_s   = 1'b0;
        gnt0_s  = gnt0_r;
        gnt1_s  = gnt1_r;
        done0_s = 1'b0;
        done1_s = 1'b0;
        busy_s  = busy_r;
        s_s     = s_r;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        win_s = ~last_r;
                    end else begin
                        win_s = req1;
                    end
                    owner_s = win_s;
                    last_s  = win_s;
                    opa_s   = win_s ? a1 : a0;
                    opb_s   = win_s ? b1 : b0;
                    cnt_s   = CNT_INIT;
                    gnt0_s  = ~win_s;
                    gnt1_s  = win_s;
                    busy_s  = 1'b1;
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 4'd0) begin
                    s_s     = sum_s;
                    done0_s = ~owner_r;
                    done1_s = owner_r;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                gnt0_s  = 1'b0;
                gnt1_s  = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                gnt0_s  = 1'b0;
                gnt1_s  = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            opa_r   <= 4'd0;
            opb_r   <= 4'd0;
            cnt_r   <= 4'd0;
            last_r  <= 1'b1;
            owner_r <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            busy_r  <= 1'b0;
            s_r     <= 5'd0;
        end else begin
            state_r <= state_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            cnt_r   <= cnt_s;
            last_r  <= last_s;
            owner_r <= owner_s;
            gnt0_r  <= gnt0_s;
            gnt1_r  <= gnt1_s;
            done0_r <= done0_s;
            done1_r <= done1_s;
            busy_r  <= busy_s;
            s_r     <= s_s;
        end
    end

    assign gnt0  = gnt0_r;
    assign gnt1  = gnt1_r;
    assign done0 = done0_r;
    assign done1 = done1_r;
    assign busy  = busy_r;
    assign s     = s_r;
endmodule

// File: tb/tb_adder_arbiter_rr.sv
// Directed bench for adder_arbiter_rr: three instances with CALC_CYCLES of 1, 3 and 4.
module tb_adder_arbiter_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // CALC_CYCLES = 1 instance
    logic       p_req0 = 1'b0, p_req1 = 1'b0;
    logic [3:0] p_a0 = 4'd0, p_b0 = 4'd0, p_a1 = 4'd0, p_b1 = 4'd0;
    logic       p_gnt0, p_gnt1, p_done0, p_done1, p_busy;
    logic [4:0] p_s;
    // CALC_CYCLES = 3 instance
    logic       q_req0 = 1'b0, q_req1 = 1'b0;
    logic [3:0] q_a0 = 4'd0, q_b0 = 4'd0, q_a1 = 4'd0, q_b1 = 4'd0;
    logic       q_gnt0, q_gnt1, q_done0, q_done1, q_busy;
    logic [4:0] q_s;
    // CALC_CYCLES = 4 instance
    logic       r_req0 = 1'b0, r_req1 = 1'b0;
    logic [3:0] r_a0 = 4'd0, r_b0 = 4'd0, r_a1 = 4'd0, r_b1 = 4'd0;
    logic       r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
    logic [4:0] r_s;

    adder_arbiter_rr #(.CALC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req0(p_req0), .a0(p_a0), .b0(p_b0),
        .req1(p_req1), .a1(p_a1), .b1(p_b1), .gnt0(p_gnt0), .gnt1(p_gnt1),
        .done0(p_done0), .done1(p_done1), .s(p_s), .busy(p_busy));
    adder_arbiter_rr #(.CALC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req0(q_req0), .a0(q_a0), .b0(q_b0),
        .req1(q_req1), .a1(q_a1), .b1(q_b1), .gnt0(q_gnt0), .gnt1(q_gnt1),
        .done0(q_done0), .done1(q_done1), .s(q_s), .busy(q_busy));
    adder_arbiter_rr #(.CALC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req0(r_req0), .a0(r_a0), .b0(r_b0),
        .req1(r_req1), .a1(r_a1), .b1(r_b1), .gnt0(r_gnt0), .gnt1(r_gnt1),
        .done0(r_done0), .done1(r_done1), .s(r_s), .busy(r_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst released 1 time unit after a rising edge; the next edge samples requests.
    task automatic do_reset();
        rst = 1'b1;
        p_req0 = 1'b0; p_req1 = 1'b0;
        q_req0 = 1'b0; q_req1 = 1'b0;
        r_req0 = 1'b0; r_req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1;
        #1;
        got = {p_gnt0, p_gnt1, p_done0, p_done1, p_busy, p_s};
        tests++;
        if (got !== 10'd0) begin
            fails++;
            $display("FAIL reset_dut1 got=%b want=%b", got, 10'd0);
        end
        tick();
        got = {q_gnt0, q_gnt1, q_done0, q_done1, q_busy, q_s};
        tests++;
        if (got !== 10'd0) begin
            fails++;
            $display("FAIL reset_dut3 got=%b want=%b", got, 10'd0);
        end
        got = {r_gnt0, r_gnt1, r_done0, r_done1, r_busy, r_s};
        tests++;
        if (got !== 10'd0) begin
            fails++;
            $display("FAIL reset_dut4 got=%b want=%b", got, 10'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        p_req0 = 1'b1; p_a0 = 4'd15; p_b0 = 4'd1;
        tick();
        p_req0 = 1'b0;
        tests++;
        if ({p_gnt0, p_gnt1, p_done0, p_busy} !== 4'b1001) begin
            fails++;
            $display("FAIL single_accept got=%b want=%b", {p_gnt0, p_gnt1, p_done0, p_busy}, 4'b1001);
        end
        tick();
        tests++;
        if ({p_gnt0, p_done0, p_done1, p_s} !== {3'b110, 5'b10000}) begin
            fails++;
            $display("FAIL single_done got=%b want=%b", {p_gnt0, p_done0, p_done1, p_s}, {3'b110, 5'b10000});
        end
        tick();
        tests++;
        if ({p_gnt0, p_done0, p_busy, p_s} !== {3'b000, 5'b10000}) begin
            fails++;
            $display("FAIL single_idle got=%b want=%b", {p_gnt0, p_done0, p_busy, p_s}, {3'b000, 5'b10000});
        end
    endtask

    task automatic test_round_robin();
        logic       exp_w;
        logic [4:0] exp_s;
        rst = 1'b1;
        p_req0 = 1'b1; p_a0 = 4'd3; p_b0 = 4'd4;
        p_req1 = 1'b1; p_a1 = 4'd9; p_b1 = 4'd9;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_w = k[0];
            exp_s = exp_w ? 5'd18 : 5'd7;
            tick();
            tests++;
            if ({p_gnt0, p_gnt1} !== {~exp_w, exp_w}) begin
                fails++;
                $display("FAIL rr_gnt k=%0d got=%b want=%b", k, {p_gnt0, p_gnt1}, {~exp_w, exp_w});
            end
            tick();
            tests++;
            if ({p_done0, p_done1, p_s} !== {~exp_w, exp_w, exp_s}) begin
                fails++;
                $display("FAIL rr_done k=%0d got=%b want=%b", k, {p_done0, p_done1, p_s}, {~exp_w, exp_w, exp_s});
            end
            tick();
            tests++;
            if ({p_done0, p_done1, p_gnt0, p_gnt1} !== 4'b0000) begin
                fails++;
                $display("FAIL rr_gap k=%0d got=%b want=%b", k, {p_done0, p_done1, p_gnt0, p_gnt1}, 4'b0000);
            end
        end
        p_req0 = 1'b0;
        p_req1 = 1'b0;
    endtask

    task automatic test_operand_change();
        do_reset();
        p_req1 = 1'b1; p_a1 = 4'd5; p_b1 = 4'd6;
        tick();
        p_a1 = 4'd0; p_b1 = 4'd0; p_req1 = 1'b0;
        tick();
        tests++;
        if ({p_gnt1, p_done0, p_done1, p_s} !== {3'b101, 5'd11}) begin
            fails++;
            $display("FAIL opchange got=%b want=%b", {p_gnt1, p_done0, p_done1, p_s}, {3'b101, 5'd11});
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [4:0] exp_s;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            p_a0 = i[7:4];
            p_b0 = i[3:0];
            exp_s = {1'b0, p_a0} + {1'b0, p_b0};
            p_req0 = 1'b1;
            tick();
            p_req0 = 1'b0;
            tick();
            tests++;
            if (p_done0 !== 1'b1 || p_s !== exp_s) begin
                fails++;
                $display("FAIL sweep ERRO a=%0d b=%0d expected=%0d obtained=%0d done0=%b", p_a0, p_b0, exp_s, p_s, p_done0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [9:0] got;
        do_reset();
        r_req0 = 1'b1; r_a0 = 4'd7; r_b0 = 4'd8;
        tick();
        r_req0 = 1'b0;
        repeat (4) tick();
        tests++;
        if ({r_done0, r_s} !== {1'b1, 5'd15}) begin
            fails++;
            $display("FAIL calc4_first got=%b want=%b", {r_done0, r_s}, {1'b1, 5'd15});
        end
        tick();
        r_req0 = 1'b1; r_a0 = 4'd1; r_b0 = 4'd2;
        tick();
        r_req0 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        got = {r_gnt0, r_gnt1, r_done0, r_done1, r_busy, r_s};
        tests++;
        if (got !== 10'd0) begin
            fails++;
            $display("FAIL midcalc_rst got=%b want=%b", got, 10'd0);
        end
        repeat (3) tick();
        tests++;
        if ({r_done0, r_done1, r_busy} !== 3'b000) begin
            fails++;
            $display("FAIL midcalc_hold got=%b want=%b", {r_done0, r_done1, r_busy}, 3'b000);
        end
        rst = 1'b0;
        r_req0 = 1'b1; r_a0 = 4'd1; r_b0 = 4'd2;
        tick();
        r_req0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++;
            if (r_done0 !== (k == 4)) begin
                fails++;
                $display("FAIL reissue_done k=%0d got=%b want=%b", k, r_done0, (k == 4));
            end
        end
        tests++;
        if (r_s !== 5'd3) begin
            fails++;
            $display("FAIL reissue_s got=%0d want=%0d", r_s, 5'd3);
        end
        tick();
    endtask

    task automatic test_calc3();
        int busy_cycles;
        do_reset();
        q_req0 = 1'b1; q_a0 = 4'd6; q_b0 = 4'd10;
        tick();
        q_req0 = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k <= 4; k++) begin
            if (q_busy === 1'b1) busy_cycles++;
            tests++;
            if (q_done0 !== (k == 3)) begin
                fails++;
                $display("FAIL calc3_done k=%0d got=%b want=%b", k, q_done0, (k == 3));
            end
            if (k == 3) begin
                tests++;
                if (q_s !== 5'd16) begin
                    fails++;
                    $display("FAIL calc3_s got=%0d want=%0d", q_s, 5'd16);
                end
            end
            tick();
        end
        tests++;
        if (busy_cycles != 4) begin
            fails++;
            $display("FAIL calc3_busy got=%0d want=%0d", busy_cycles, 4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_operand_change();
        test_sweep();
        test_reset_mid_calc();
        test_calc3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
